// File: rtl/mem_responder.sv
// mem_responder: one 16-bit storage array shared by the fetch and data initiators.
// One access is in flight at a time and completes a fixed LATENCY cycles after it
// is accepted. The data port always wins over the fetch port.
module mem_responder #(
    parameter int LATENCY = 4,
    parameter int ADDR_W  = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [15:0] i_addr,
    output logic        i_rdy,
    output logic        i_valid,
    output logic [15:0] i_data,
    input  logic        d_req,
    input  logic        d_wr,
    input  logic [15:0] d_addr,
    input  logic [15:0] d_wdata,
    output logic        d_rdy,
    output logic        d_valid,
    output logic [15:0] d_rdata,
    output logic        busy
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [3:0] LAST_CNT = 4'(LATENCY - 1);

    typedef enum logic {IDLE, BUSY} state_e;

    state_e             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;

    logic               op_is_data_q;
    logic               op_wr_q;
    logic [ADDR_W-1:0]  op_idx_q;
    logic [15:0]        op_wdata_q;

    logic [15:0]        mem_q [DEPTH];

    logic               i_valid_q, d_valid_q;
    logic [15:0]        i_data_q, d_rdata_q;

    logic               accept;
    logic               fire;
    logic               fire_is_data;
    logic               fire_wr;
    logic [ADDR_W-1:0]  fire_idx;
    logic [15:0]        fire_wdata;

    logic [ADDR_W-1:0]  i_idx, d_idx;
    logic               unused_addr_bits;

    // Byte address to word index; bit 0 and bits above the index alias away.
    assign i_idx            = i_addr[ADDR_W:1];
    assign d_idx            = d_addr[ADDR_W:1];
    assign unused_addr_bits = ^{i_addr, d_addr};

    assign i_valid = i_valid_q;
    assign d_valid = d_valid_q;
    assign i_data  = i_data_q;
    assign d_rdata = d_rdata_q;

    // State and latency counter; reset abandons whatever access was in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: count through the latency window, back to IDLE on the completing edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept && (LATENCY > 1)) begin
                    state_d = BUSY;
                    cnt_d   = 4'd1;
                end
            end
            BUSY: begin
                if (cnt_q == LAST_CNT) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Handshakes and the access that completes on the coming edge (taken straight from the ports when LATENCY is 1).
    always_comb begin
        d_rdy  = (state_q == IDLE) && d_req && !rst;
        i_rdy  = (state_q == IDLE) && i_req && !d_req && !rst;
        accept = d_rdy || i_rdy;
        busy   = (state_q == BUSY);
        if (LATENCY == 1) begin
            fire         = accept;
            fire_is_data = d_rdy;
            fire_wr      = d_rdy && d_wr;
            fire_idx     = d_rdy ? d_idx : i_idx;
            fire_wdata   = d_wdata;
        end else begin
            fire         = (state_q == BUSY) && (cnt_q == LAST_CNT);
            fire_is_data = op_is_data_q;
            fire_wr      = op_wr_q;
            fire_idx     = op_idx_q;
            fire_wdata   = op_wdata_q;
        end
    end

    // Capture the request at acceptance so later changes on the ports are ignored.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_is_data_q <= 1'b0;
            op_wr_q      <= 1'b0;
            op_idx_q     <= '0;
            op_wdata_q   <= '0;
        end else if (accept) begin
            op_is_data_q <= d_rdy;
            op_wr_q      <= d_rdy && d_wr;
            op_idx_q     <= d_rdy ? d_idx : i_idx;
            op_wdata_q   <= d_wdata;
        end
    end

    // Response pulses and read data, sampled from the array on the completing edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i_valid_q <= 1'b0;
            d_valid_q <= 1'b0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
        end else begin
            i_valid_q <= fire && !fire_is_data;
            d_valid_q <= fire && fire_is_data;
            if (fire && !fire_is_data) begin
                i_data_q <= mem_q[fire_idx];
            end
            if (fire && fire_is_data && !fire_wr) begin
                d_rdata_q <= mem_q[fire_idx];
            end
        end
    end

    // Storage array, written on the edge that raises d_valid; contents survive reset.
    always_ff @(posedge clk) begin
        if (fire && fire_is_data && fire_wr) begin
            mem_q[fire_idx] <= fire_wdata;
        end
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Multi-cycle memory responder servicing the pipeline's two memory initiators: the instruction-fetch port and the data (load/store) port.
- Holds a single 16-bit-wide storage array and accepts one request at a time, with fixed access latency LATENCY.
- The data port has priority over the fetch port.
- Drives per-port ready and valid signals; the CPU hazard logic uses them to stall IF and MEM.

Parameters:
LATENCY, 4, cycles from request acceptance to response valid (legal range 1..15)
ADDR_W, 12, number of word-address bits; array depth is 2^ADDR_W words

Ports:
clk  input  1  system clock, rising-edge
rst  input  1  asynchronous reset, active-high
i_req  input  1  fetch read request; held until accepted
i_addr  input  16  fetch byte address
i_rdy  output  1  fetch request accepted this cycle (combinational)
i_valid  output  1  fetch read data valid, one-cycle pulse
i_data  output  16  fetch read data
d_req  input  1  data request; held until accepted
d_wr  input  1  1 = store, 0 = load; qualified by d_req
d_addr  input  16  data byte address
d_wdata  input  16  store data
d_rdy  output  1  data request accepted this cycle (combinational)
d_valid  output  1  load data valid / store complete, one-cycle pulse
d_rdata  output  16  load data
busy  output  1  access in flight

Behaviour:
- Addressing:
  - Word index is addr[ADDR_W:1]; addr[0] is ignored.
  - Bits above ADDR_W are ignored, so addresses alias.
- States:
  - IDLE: no access in flight.
  - BUSY: counter cnt runs 1..LATENCY-1.
  - Captured at acceptance: port id (I/D), wr, word index, wdata.
- Acceptance, only in IDLE:
  - d_rdy = IDLE & d_req.
  - i_rdy = IDLE & i_req & ~d_req.
  - At most one rdy is high per cycle. Fixed priority: a continuous d_req starves fetch, and this is intended.
- Timing:
  - Request accepted in cycle T → matching valid is high in cycle T+LATENCY for exactly one cycle.
  - busy is high in cycles T+1..T+LATENCY-1.
  - LATENCY=1: valid in T+1, busy never high.
- Completion:
  - The FSM returns to IDLE in the valid cycle, so a new request can be accepted in that same cycle.
  - Maximum throughput is one access per LATENCY cycles.
- Reads:
  - Data is sampled from the array on the clock edge that raises valid.
  - i_data / d_rdata are registered and hold their last value between pulses.
- Writes:
  - The array is updated on the clock edge that raises d_valid.
  - d_rdata is unchanged on a store.
- Ordering:
  - A read accepted in the store's d_valid cycle or later returns the new data.
  - Only one access is ever in flight, so no other hazard exists.
- Request inputs are sampled only at acceptance. Changes to addr/wdata afterwards have no effect.
- req dropped before acceptance: no access occurs.
- Reset (asynchronous, any time, including mid-access):
  - FSM → IDLE, cnt=0.
  - i_valid=d_valid=0, i_data=d_rdata=0, busy=0.
  - The in-flight access is aborted: no valid pulse, and an aborted store does not write.
  - Array contents are not reset. Reads of never-written words are undefined; the bench must write before reading.
- While rst is high, i_rdy=d_rdy=0.

Test Plan:
1. LATENCY=4. Store d_addr=0x0010, d_wdata=0xBEEF accepted at T0, then load 0x0010 held → d_rdy at T0, d_valid at T4; load accepted at T4, d_valid at T8 with d_rdata=0xBEEF; busy high T1-T3 and T5-T7.
2. Preload word 0x0002=0x1234. Raise i_req (addr 0x0004) and d_req (load 0x0002) in the same cycle T0 → d_rdy=1, i_rdy=0 at T0; d_valid at T4 with 0x1234; i_rdy at T4; i_valid at T8 with contents of word 2.
3. i_req held during a busy access → i_rdy stays 0 until the valid cycle; i_data keeps its old value and i_valid stays 0 meanwhile.
4. Store 0xAAAA to 0x0020 accepted at T0; assert rst at T2 for one cycle; later load 0x0020 → no d_valid at T4; load returns the prior value (0x5555, written earlier), not 0xAAAA; all outputs 0 during reset.
5. ADDR_W=12: store 0x7777 to 0x2000, load 0x0000 → returns 0x7777 (aliasing). Load 0x0001 → returns 0x7777 (bit0 ignored).
6. LATENCY=1: back-to-back loads of the fetch port every cycle → i_rdy and i_valid high every cycle, i_data tracking each address one cycle later; busy never high.
